fp_result_display: RTL and testbench
====================================

Name: fp_result_display

Overview:
Parametrised successor to the two-digit result display used by the FP adder system. It accepts floating-point adder results over a valid/ready stream and buffers them in a DEPTH-entry FIFO. Each result is shown for HOLD_CYCLES on NUM_DIGITS time-multiplexed hex seven-segment digits, with a selectable nibble page. It sits between the FP adder datapath and the board display/LED pins in the system top level.

Parameters:
DATA_W, 32, result word width; must be a multiple of 4*NUM_DIGITS.
NUM_DIGITS, 4, number of multiplexed seven-segment digits (2..8).
DEPTH, 8, FIFO entries; power of two, at least 2.
HOLD_CYCLES, 50000000, clock cycles each result stays on the display (at least 2).
REFRESH_CYCLES, 100000, clock cycles each digit stays enabled per scan (at least 1).
PAGES, DATA_W/(4*NUM_DIGITS), derived; number of nibble windows.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-low (rst=0 resets on the rising clk edge).
in_data  in  DATA_W  result word.
in_valid  in  1  in_data is valid.
in_ready  out  1  FIFO can accept a word; equals !full, combinational from the occupancy count.
page_sel  in  max(1,clog2(PAGES))  selects the nibble window; values >= PAGES behave as PAGES-1.
an  out  NUM_DIGITS  digit enables, active-low, one-hot.
seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
dp  out  1  decimal point, active-low.
leds  out  8  count of results displayed so far, mod 256.

Behaviour:
- Reset (rst=0):
  - FIFO flushed; state EMPTY; display register cleared.
  - Hold and refresh counters cleared; digit index 0.
  - Outputs: an all 1s, seg 7'h7F, dp 1, leds 0, in_ready 1.
  - Reset takes effect mid-operation with no partial pop or push.
- Push: occurs when in_valid && in_ready. in_valid while full is ignored; the source must hold the word until in_ready.
- FIFO corner cases:
  - Push and pop in the same cycle: count unchanged, both take effect. When full, a pop frees space only from the next cycle, because in_ready is derived from the registered count.
  - Pointers wrap modulo DEPTH.
- State machine:
  - EMPTY: display blanked (an all 1s). If the FIFO is non-empty, pop into the display register, clear the hold counter, increment leds, go to HOLD.
  - HOLD: the hold counter counts up. When it reaches HOLD_CYCLES-1:
    - FIFO non-empty: pop, reload, increment leds, stay in HOLD.
    - FIFO empty: go to WAIT.
  - WAIT: the last value stays displayed. When the FIFO becomes non-empty, pop immediately, clear the hold counter, increment leds, go to HOLD.
- Latency: a word pushed at edge t into an empty FIFO in EMPTY is popped at edge t+1. an, seg and dp are registered and reflect it after edge t+2.
- Scanning:
  - The refresh counter advances the digit index every REFRESH_CYCLES cycles, wrapping NUM_DIGITS-1 to 0.
  - an[i]=0 only for the current index i.
  - The digit shows nibble i of window p, i.e. bits [4*(p*NUM_DIGITS+i)+3 : 4*(p*NUM_DIGITS+i)]. Digit 0 is the least-significant nibble.
  - Scanning runs in every state; in EMPTY, an is forced to all 1s.
- Hex encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- dp = 0 on digit NUM_DIGITS-1 when the effective page is non-zero and in WAIT on digit 0. Otherwise dp = 1.
- page_sel changes take effect on the next registered output update, with no state change.

Decomposition:
- Package fp_disp_pkg:
  - the 16-entry hex-to-segment constant table;
  - the state enum (EMPTY, HOLD, WAIT);
  - SEG_BLANK = 7'h7F.
- Sub-module sync_fifo (DATA_W, DEPTH): push/pop, full/empty, registered count, same synchronous active-low rst.
- The scan/decode logic stays in the top-level block.

Test Plan:
Use NUM_DIGITS=4, DEPTH=4, HOLD_CYCLES=4, REFRESH_CYCLES=2.
- Reset: rst=0 for 2 cycles, then 1 -> an=4'b1111, seg=7'h7F, dp=1, leds=0, in_ready=1.
- Push 32'h3F800000 with page_sel=1:
  - after 2 edges, an scans 1110, 1101, 1011, 0111 every 2 cycles;
  - seg follows 1000000 (0), 0000000 (8), 0001110 (F), 0110000 (3);
  - dp=0 only while an=0111;
  - leds=1.
- Burst push of 6 words while the first is held -> in_ready drops after 4 words are queued and reasserts once a pop frees a slot. All 6 are displayed in order, each for 4 cycles; leds=6.
- After a single word, the hold expires -> state WAIT, the value is retained and dp=0 on digit 0. Push 32'h40000000 -> it is displayed within 2 edges; leds=2.
- Push/pop collision: FIFO full at a hold expiry with in_valid high -> no word is lost or duplicated. The checker compares the display sequence against a scoreboard.
- Reset mid-HOLD with 3 entries queued -> the next cycle shows blank display, leds=0, in_ready=1, and no stale word appears afterwards.

Source files
------------

// File: rtl/fp_disp_pkg.sv
// Shared types and constants for the FP result display.
//   disp_state_t : display sequencer states
//   SEG_BLANK    : all segments off (active-low)
//   HEX_SEG      : hex digit -> {g,f,e,d,c,b,a} active-low, index = nibble value
package fp_disp_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        WAIT  = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Packed so that HEX_SEG[n] selects the pattern for nibble n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read data.
//   clk, rst      : clock, synchronous active-low reset
//   push, wdata   : write strobe/data (caller guarantees !full)
//   pop, rdata    : read strobe (caller guarantees !empty); rdata is the head entry
//   full, empty   : decoded from the registered occupancy count
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic [AW:0]       count;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fp_result_display.sv
// Buffers FP adder results and shows each one for HOLD_CYCLES on a
// multiplexed hex seven-segment display.
//   clk, rst           : clock, synchronous active-low reset
//   in_data/in_valid   : result stream in; in_ready = FIFO not full
//   page_sel           : nibble window (clamped to PAGES-1)
//   an, seg, dp        : digit enables, segments, decimal point (all active-low, registered)
//   leds               : number of results displayed so far, mod 256
module fp_result_display
    import fp_disp_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int NUM_DIGITS     = 4,
    parameter int DEPTH          = 8,
    parameter int HOLD_CYCLES    = 50000000,
    parameter int REFRESH_CYCLES = 100000,
    localparam int PAGES  = DATA_W / (4 * NUM_DIGITS),
    localparam int PSEL_W = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PSEL_W-1:0]     page_sel,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [7:0]            leds
);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYCLES - 1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

    disp_state_t       state, state_n;
    logic [HW-1:0]     hold_cnt, hold_n;
    logic [RW-1:0]     ref_cnt;
    logic [DW-1:0]     dig;
    logic [DATA_W-1:0] disp;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic              push, pop;

    logic [NUM_DIGITS-1:0] an_n;
    logic [6:0]            seg_n;
    logic                  dp_n;
    logic [3:0]            nib;
    int                    pg;

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sequencer: every pop loads the display register and restarts the hold.
    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        pop     = 1'b0;
        case (state)
            EMPTY, WAIT: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_n  = '0;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        hold_n = '0;
                    end else begin
                        state_n = WAIT;
                    end
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // Next display outputs from the current digit and window.
    always_comb begin
        pg    = (int'(page_sel) >= PAGES) ? PAGES - 1 : int'(page_sel);
        nib   = 4'(disp >> (4 * (pg * NUM_DIGITS + int'(dig))));
        an_n  = ~(NUM_DIGITS'(1) << dig);
        seg_n = HEX_SEG[nib];
        dp_n  = 1'b1;
        // Top digit dot flags a non-zero page; digit-0 dot flags a stale value.
        if ((dig == DIG_LAST && pg != 0) || (state == WAIT && dig == '0))
            dp_n = 1'b0;
        if (state == EMPTY) begin
            an_n  = '1;
            seg_n = SEG_BLANK;
            dp_n  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= EMPTY;
            hold_cnt <= '0;
            disp     <= '0;
            leds     <= '0;
            ref_cnt  <= '0;
            dig      <= '0;
            an       <= '1;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            if (pop) begin
                disp <= fifo_rdata;
                leds <= leds + 8'd1;
            end
            if (ref_cnt == REF_LAST) begin
                ref_cnt <= '0;
                dig     <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            an  <= an_n;
            seg <= seg_n;
            dp  <= dp_n;
        end
    end

endmodule

// File: tb/tb_fp_result_display.sv
module tb_fp_result_display;
    localparam int DATA_W = 32, ND = 4, DEPTH = 4, HOLD = 4, REFR = 2, PAGES = 2;
    localparam int M_EMPTY = 0, M_HOLD = 1, M_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [0:0]  page_sel = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  leds;

    fp_result_display #(
        .DATA_W(DATA_W), .NUM_DIGITS(ND), .DEPTH(DEPTH),
        .HOLD_CYCLES(HOLD), .REFRESH_CYCLES(REFR)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .page_sel(page_sel), .an(an), .seg(seg),
        .dp(dp), .leds(leds)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model: queue-based FIFO, age of the shown word, scan position.
    logic [31:0] mq[$], pend[$], sent[$];
    int          m_state, m_age, m_dig, m_ref, m_leds;
    logic [31:0] m_disp;
    bit          m_pushed;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    task automatic model_step();
        int pe, nib;
        bit expire;
        m_pushed = 0;
        if (!rst) begin
            mq.delete();
            m_state = M_EMPTY; m_age = 0; m_disp = '0; m_leds = 0; m_ref = 0; m_dig = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            return;
        end
        pe = (int'(page_sel) > PAGES - 1) ? PAGES - 1 : int'(page_sel);
        if (m_state == M_EMPTY) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an  = 4'hF ^ (4'b0001 << m_dig);
            nib   = int'((m_disp >> (4 * (pe * ND + m_dig))) & 32'hF);
            e_seg = hex_tab[nib];
            e_dp  = ((m_dig == ND - 1 && pe != 0) || (m_state == M_WAIT && m_dig == 0)) ? 1'b0 : 1'b1;
        end
        m_ref++;
        if (m_ref == REFR) begin m_ref = 0; m_dig = (m_dig + 1) % ND; end
        m_pushed = in_valid && (mq.size() < DEPTH);
        expire   = (m_state == M_HOLD) && (m_age + 1 >= HOLD);
        if (m_state == M_HOLD && !expire) m_age++;
        if ((m_state != M_HOLD || expire) && mq.size() > 0) begin
            m_disp = mq.pop_front();
            m_age = 0; m_leds++; m_state = M_HOLD;
        end else if (expire) begin
            m_state = M_WAIT;
        end
        if (m_pushed) mq.push_back(in_data);
    endtask

    function automatic logic [20:0] exp_vec();
        return {e_an, e_seg, e_dp, 8'(m_leds), 1'(mq.size() < DEPTH)};
    endfunction

    // One clock: model sees the same inputs as the DUT edge; new inputs at negedge.
    task automatic step();
        @(posedge clk);
        model_step();
        if (m_pushed) sent.push_back(pend.pop_front());
        @(negedge clk);
        in_valid = (pend.size() > 0);
        in_data  = in_valid ? pend[0] : 32'h0;
    endtask

    task automatic send(input logic [31:0] w);
        pend.push_back(w);
        in_valid = 1'b1;
        in_data  = pend[0];
    endtask

    task automatic do_reset();
        rst = 1'b0; pend.delete(); sent.delete();
        in_valid = 1'b0; in_data = '0;
        step(); step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (an !== 4'hF)     begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
        checks++; if (seg !== 7'h7F)   begin errors++; $display("FAIL reset_seg: got %b want 1111111", seg); end
        checks++; if (dp !== 1'b1)     begin errors++; $display("FAIL reset_dp: got %b want 1", dp); end
        checks++; if (leds !== 8'd0)   begin errors++; $display("FAIL reset_leds: got %0d want 0", leds); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if ({an, seg, dp, leds, in_ready} !== exp_vec()) begin
                errors++; $display("FAIL reset_idle c%0d: got %b want %b", c, {an, seg, dp, leds, in_ready}, exp_vec());
            end
        end
    endtask

    task automatic test_single_scan();
        page_sel = 1'b1;
        send(32'h3F800000);
        step(); step(); step();
        checks++; if (an === 4'hF)  begin errors++; $display("FAIL single_latency: got an=%b want a digit enabled", an); end
        checks++; if (leds !== 8'd1) begin errors++; $display("FAIL single_leds: got %0d want 1", leds); end
        for (int c = 0; c < 16; c++) begin
            logic [6:0] want;
            step();
            checks++;
            if ({an, seg, dp, leds, in_ready} !== exp_vec()) begin
                errors++; $display("FAIL single_model c%0d: got %b want %b", c, {an, seg, dp, leds, in_ready}, exp_vec());
            end
            case (an)
                4'b1110: want = 7'b1000000;
                4'b1101: want = 7'b0000000;
                4'b1011: want = 7'b0001110;
                default: want = 7'b0110000;
            endcase
            checks++; if (seg !== want) begin errors++; $display("FAIL single_seg an=%b: got %b want %b", an, seg, want); end
            if (an == 4'b0111) begin
                checks++; if (dp !== 1'b0) begin errors++; $display("FAIL single_dp: got %b want 0", dp); end
            end
        end
    endtask

    task automatic test_wait();
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if ({an, seg, dp, leds, in_ready} !== exp_vec()) begin
                errors++; $display("FAIL wait_model c%0d: got %b want %b", c, {an, seg, dp, leds, in_ready}, exp_vec());
            end
            if (an == 4'b1110) begin
                checks++; if (dp !== 1'b0) begin errors++; $display("FAIL wait_dp0: got %b want 0", dp); end
            end
        end
        send(32'h40000000);
        step(); step(); step();
        checks++; if (leds !== 8'd2) begin errors++; $display("FAIL wait_leds: got %0d want 2", leds); end
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if ({an, seg, dp, leds, in_ready} !== exp_vec()) begin
                errors++; $display("FAIL wait_new c%0d: got %b want %b", c, {an, seg, dp, leds, in_ready}, exp_vec());
            end
            if (an == 4'b0111) begin
                checks++; if (seg !== 7'b0011001) begin errors++; $display("FAIL wait_new_seg: got %b want 0011001", seg); end
            end
        end
    endtask

    task automatic test_burst();
        bit saw_block = 0;
        int c;
        do_reset();
        page_sel = 1'b0;
        for (int i = 0; i < 6; i++) send($urandom);
        for (c = 0; c < 100; c++) begin
            if (pend.size() == 0 && mq.size() == 0 && m_state == M_WAIT) break;
            if (in_valid && !in_ready) saw_block = 1;
            step();
            checks++;
            if ({an, seg, dp, leds, in_ready} !== exp_vec()) begin
                errors++; $display("FAIL burst c%0d: got %b want %b", c, {an, seg, dp, leds, in_ready}, exp_vec());
            end
        end
        checks++; if (c >= 100)    begin errors++; $display("FAIL burst_timeout: got %0d cycles want <100", c); end
        checks++; if (!saw_block)  begin errors++; $display("FAIL burst_backpressure: got in_ready never low want low once"); end
        checks++; if (leds !== 8'd6) begin errors++; $display("FAIL burst_leds: got %0d want 6", leds); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL burst_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_collision();
        int c;
        int start_leds = int'(leds);
        sent.delete();
        for (int i = 0; i < 10; i++) send($urandom);
        for (c = 0; c < 200; c++) begin
            if (pend.size() == 0 && mq.size() == 0 && m_state == M_WAIT) break;
            step();
            checks++;
            if ({an, seg, dp, leds, in_ready} !== exp_vec()) begin
                errors++; $display("FAIL collision c%0d: got %b want %b", c, {an, seg, dp, leds, in_ready}, exp_vec());
            end
        end
        checks++; if (c >= 200) begin errors++; $display("FAIL collision_timeout: got %0d cycles want <200", c); end
        checks++;
        if (leds !== 8'(start_leds + sent.size()) || sent.size() != 10) begin
            errors++; $display("FAIL collision_count: got leds=%0d sent=%0d want leds=%0d sent=10", leds, sent.size(), start_leds + 10);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) send($urandom);
        step(); step(); step(); step();
        rst = 1'b0; pend.delete(); in_valid = 1'b0; in_data = '0;
        step();
        rst = 1'b1;
        checks++;
        if ({an, seg, dp, leds, in_ready} !== {4'hF, 7'h7F, 1'b1, 8'd0, 1'b1}) begin
            errors++; $display("FAIL reset_mid: got %b want %b", {an, seg, dp, leds, in_ready}, {4'hF, 7'h7F, 1'b1, 8'd0, 1'b1});
        end
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            if (an !== 4'hF || leds !== 8'd0) begin
                errors++; $display("FAIL reset_mid_stale c%0d: got an=%b leds=%0d want an=1111 leds=0", c, an, leds);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (pend.size() == 0 && $urandom_range(2, 0) == 0) send($urandom);
            if ($urandom_range(7, 0) == 0) page_sel = 1'($urandom);
            step();
            checks++;
            if ({an, seg, dp, leds, in_ready} !== exp_vec()) begin
                errors++; $display("FAIL random c%0d: got %b want %b", c, {an, seg, dp, leds, in_ready}, exp_vec());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_scan();
        test_wait();
        test_burst();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
